// File: rtl/bcd_display_pkg.sv
// Shared constants for the 3-digit multiplexed 7-segment display path.
// Glyphs are {g,f,e,d,c,b,a}, active-low (common-anode).
package bcd_display_pkg;

    localparam int NUM_DIGITS = 3;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [2:0] AN_OFF = 3'b111;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD nibble to active-low 7-segment glyph; A-F show a dash.
module seg7_decoder
    import bcd_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_DASH;
        case (nibble)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Scans a double-buffered 3-digit BCD value onto a common-anode display with
// per-slot anti-ghosting blank cycles and optional leading-zero suppression.
module bcd_display_scanner
    import bcd_display_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic        frame_start
);

    localparam int              CntW    = $clog2(REFRESH_DIV);
    localparam logic [CntW-1:0] CntMax  = CntW'(REFRESH_DIV - 1);
    localparam digit_idx_t      LastIdx = digit_idx_t'(NUM_DIGITS - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    digit_idx_t      idx_q, idx_d;
    logic [11:0]     hold_q, hold_d;
    logic [11:0]     shadow_q, shadow_d;
    logic            pending_q, pending_d;
    logic [6:0]      seg_q, seg_d;
    logic [2:0]      an_q, an_d;
    logic            fs_q, fs_d;

    logic            frame_end;
    logic [3:0]      nib;
    logic            lz;
    logic [6:0]      glyph;
    logic [2:0]      an_sel;

    assign frame_end = (idx_q == LastIdx) && (cnt_q == CntMax);

    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        hold_d    = hold_q;
        pending_d = pending_q;
        shadow_d  = shadow_q;

        if (cnt_q == CntMax) begin
            cnt_d = '0;
            idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
        end

        if (load) begin
            hold_d    = bcd_in;
            pending_d = 1'b1;
        end

        // A load on the frame-end cycle bypasses hold and lands in this frame's commit.
        if (frame_end) begin
            if (load) begin
                shadow_d = bcd_in;
            end else if (pending_q) begin
                shadow_d = hold_q;
            end
            pending_d = 1'b0;
        end
    end

    always_comb begin
        nib    = shadow_q[3:0];
        lz     = 1'b0;
        an_sel = 3'b110;
        case (idx_q)
            2'd1: begin
                nib    = shadow_q[7:4];
                lz     = (shadow_q[11:4] == 8'd0);
                an_sel = 3'b101;
            end
            2'd2: begin
                nib    = shadow_q[11:8];
                lz     = (shadow_q[11:8] == 4'd0);
                an_sel = 3'b011;
            end
            default: begin
                nib    = shadow_q[3:0];
                lz     = 1'b0;
                an_sel = 3'b110;
            end
        endcase
    end

    seg7_decoder u_dec (
        .nibble (nib),
        .glyph  (glyph)
    );

    always_comb begin
        fs_d  = (idx_q == '0) && (cnt_q == '0);
        seg_d = glyph;
        an_d  = an_sel;
        if ((int'(cnt_q) < BLANK_CYCLES) || (blank_lz && lz)) begin
            seg_d = SEG_OFF;
            an_d  = AN_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            hold_q    <= '0;
            pending_q <= 1'b0;
            shadow_q  <= '0;
            seg_q     <= SEG_OFF;
            an_q      <= AN_OFF;
            fs_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            fs_q      <= fs_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign frame_start = fs_q;

endmodule
